branch_predict_resolve_unit: RTL and testbench
==============================================

BRANCH_PREDICT_RESOLVE_UNIT -- requirements
Module: branch_predict_resolve_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and rst.
REQ-002 Parameters SHALL be:
- DATA_W, 32: operand width.
- BHT_DEPTH, 64: number of 2-bit counters; a power of two, 4..1024.
- IDX_W, $clog2(BHT_DEPTH): counter index width.

REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lookup_pc  in  32  PC of the decode-stage instruction.
- predict_taken  out  1  combinational prediction for lookup_pc.
- res_valid  in  1  execute-stage branch present.
- res_code  in  6  branch code.
- res_pc  in  32  PC of the resolving branch.
- res_op0, res_op1  in  DATA_W  compared operands.
- res_pred  in  1  prediction carried with the branch.
- taken  out  1  registered resolved direction.
- mispredict  out  1  registered one-cycle redirect pulse.
- stat_branches, stat_mispredicts  out  32  counters (REQ-019).

Function
REQ-004 Branch codes SHALL be:
- BEQ 6'h03: taken if op0 == op1.
- BNE 6'h04: taken if op0 != op1.
- BLEZ 6'h07: taken if signed op0 <= 0.
- BGTZ 6'h0F: taken if signed op0 > 0.
- BGEZ 6'h11: taken if signed op0 >= 0.
- BLTZ 6'h13: taken if signed op0 < 0.

REQ-005 Comparisons SHALL use all DATA_W bits; signed tests SHALL treat bit DATA_W-1 as the sign bit; op1 SHALL be ignored for single-operand codes.
REQ-006 Counter index SHALL be pc[IDX_W+1:2] for both lookup and update.
REQ-007 predict_taken SHALL equal bit 1 of the counter at the lookup index, with zero-cycle latency.
REQ-008 Each counter SHALL be a 2-bit saturating state machine with these states and transitions:
- SNT(00) -> WNT(01) -> WT(10) -> ST(11) on taken.
- The reverse direction on not-taken.
- Saturation at 00 and 11.

REQ-009 On a clock edge with res_valid=1 and a valid code, the indexed counter SHALL update toward the resolved direction; the new value SHALL be visible to lookup from the following cycle.
REQ-010 A same-cycle lookup of the index being updated SHALL return the pre-update value (no bypass).
REQ-011 taken and mispredict SHALL be registered, appearing exactly one cycle after the res_valid cycle.
REQ-012 For a valid code, mispredict SHALL be 1 for one cycle when the resolved direction != res_pred.
REQ-013 With res_valid=0, the next-cycle taken and mispredict SHALL be 0.
REQ-014 An unrecognised res_code with res_valid=1 SHALL give taken=0 and mispredict=0, and SHALL leave the table unchanged.
REQ-015 Back-to-back resolves to the same index SHALL each apply one counter step in order.

Reset
REQ-016 While rst=1:
- All counters SHALL be WNT(01).
- taken and mispredict SHALL be 0.
- The statistics counters SHALL be 0.

REQ-017 rst SHALL take priority over a simultaneous res_valid; that resolve SHALL be discarded and produce no output pulse.
REQ-018 predict_taken SHALL read 0 in the first cycle after reset is released.

Configuration
REQ-019 Macro BRU_STATS_EN SHALL control the statistics counters:
- Defined: stat_branches SHALL increment on each valid-code resolve, and stat_mispredicts SHALL increment on each mispredict.
- Both counters SHALL be 32-bit and saturate at 32'hFFFFFFFF.
- Undefined: both ports SHALL be tied to 0 and no counter flops SHALL be synthesised.

Verification
REQ-020 Reset, then BEQ at pc 0x40, op0=op1=5, res_pred=0 -> next cycle taken=1, mispredict=1; predict_taken for 0x40 becomes 1.
REQ-021 Four successive taken BNE at pc 0x80 -> counter sequence 01,10,11,11; one not-taken then gives 10, and predict_taken stays 1.
REQ-022 DATA_W=32: BLTZ with op0=32'h80000000 -> taken=1; BGTZ with op0=0 -> taken=0; BLEZ with op0=0 -> taken=1.
REQ-023 Lookup and update of index 3 in the same cycle, counter at 01 and resolving taken -> predict_taken=0 in that cycle and 1 in the next.
REQ-024 rst asserted in the same cycle as res_valid with a mispredicting BEQ -> mispredict stays 0 and every counter reads 01.
REQ-025 BRU_STATS_EN defined, 10 resolves with 3 mispredicts plus one res_code=6'h3F -> stat_branches=10, stat_mispredicts=3.

Source files
------------

// File: rtl/branch_predict_resolve_unit.sv
// Branch resolve unit with a bimodal table of 2-bit saturating counters for prediction.
// Statistics counters are built only when the macro BRU_STATS_EN is defined.
module branch_predict_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       lookup_pc,
    output logic              predict_taken,
    input  logic              res_valid,
    input  logic [5:0]        res_code,
    input  logic [31:0]       res_pc,
    input  logic [DATA_W-1:0] res_op0,
    input  logic [DATA_W-1:0] res_op1,
    input  logic              res_pred,
    output logic              taken,
    output logic              mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [5:0] C_BEQ  = 6'h03;
    localparam logic [5:0] C_BNE  = 6'h04;
    localparam logic [5:0] C_BLEZ = 6'h07;
    localparam logic [5:0] C_BGTZ = 6'h0F;
    localparam logic [5:0] C_BGEZ = 6'h11;
    localparam logic [5:0] C_BLTZ = 6'h13;

    ctr_t             r_bht [BHT_DEPTH];
    logic             r_taken;
    logic             r_mispredict;
    logic [IDX_W-1:0] w_lookupIdx;
    logic [IDX_W-1:0] w_resIdx;
    ctr_t             w_lookupCtr;
    ctr_t             w_resCtr;
    ctr_t             w_resCtrNext;
    logic             w_codeValid;
    logic             w_dir;
    logic             w_op0Neg;
    logic             w_op0Zero;
    logic             w_resolve;
    logic             w_unused;

    assign w_lookupIdx   = lookup_pc[IDX_W+1:2];
    assign w_resIdx      = res_pc[IDX_W+1:2];
    assign w_lookupCtr   = r_bht[w_lookupIdx];
    assign w_resCtr      = r_bht[w_resIdx];
    assign predict_taken = w_lookupCtr[1];
    assign w_op0Neg      = res_op0[DATA_W-1];
    assign w_op0Zero     = (res_op0 == '0);
    assign w_resolve     = res_valid & w_codeValid;
    assign taken         = r_taken;
    assign mispredict    = r_mispredict;
    assign w_unused      = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                             res_pc[31:IDX_W+2], res_pc[1:0]};

    // Single-operand codes look only at the sign bit and zero-ness of op0.
    always_comb begin
        w_codeValid = 1'b1;
        w_dir       = 1'b0;
        case (res_code)
            C_BEQ:   w_dir = (res_op0 == res_op1);
            C_BNE:   w_dir = (res_op0 != res_op1);
            C_BLEZ:  w_dir = w_op0Neg | w_op0Zero;
            C_BGTZ:  w_dir = ~w_op0Neg & ~w_op0Zero;
            C_BGEZ:  w_dir = ~w_op0Neg;
            C_BLTZ:  w_dir = w_op0Neg;
            default: w_codeValid = 1'b0;
        endcase
    end

    always_comb begin
        w_resCtrNext = w_resCtr;
        case (w_resCtr)
            SNT: w_resCtrNext = w_dir ? WNT : SNT;
            WNT: w_resCtrNext = w_dir ? WT  : SNT;
            WT:  w_resCtrNext = w_dir ? ST  : WNT;
            ST:  w_resCtrNext = w_dir ? ST  : WT;
            default: w_resCtrNext = WNT;
        endcase
    end

    // Table writes land after the edge, so a same-cycle lookup sees the old counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= WNT;
            end
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_taken      <= w_resolve & w_dir;
            r_mispredict <= w_resolve & (w_dir ^ res_pred);
            if (w_resolve) begin
                r_bht[w_resIdx] <= w_resCtrNext;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] r_statBranches;
    logic [31:0] r_statMispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_statBranches    <= '0;
            r_statMispredicts <= '0;
        end else if (w_resolve) begin
            if (r_statBranches != 32'hFFFF_FFFF) begin
                r_statBranches <= r_statBranches + 32'd1;
            end
            if ((w_dir ^ res_pred) && (r_statMispredicts != 32'hFFFF_FFFF)) begin
                r_statMispredicts <= r_statMispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_statBranches;
    assign stat_mispredicts = r_statMispredicts;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Self-checking bench for branch_predict_resolve_unit: vector table, directed
// corner sequences and randomized traffic against a behavioural counter-table model.
module tb_branch_predict_resolve_unit;
    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic        res_valid;
    logic [5:0]  res_code;
    logic [31:0] res_pc;
    logic [31:0] res_op0;
    logic [31:0] res_op1;
    logic        res_pred;
    logic        taken;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predict_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .predict_taken    (predict_taken),
        .res_valid        (res_valid),
        .res_code         (res_code),
        .res_pc           (res_pc),
        .res_op0          (res_op0),
        .res_op1          (res_op1),
        .res_pred         (res_pred),
        .taken            (taken),
        .mispredict       (mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [5:0]  code;
        logic [31:0] pc;
        logic [31:0] op0;
        logic [31:0] op1;
        bit          pred;
        bit          expTaken;
        bit          expMis;
    } vec_t;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          bht [64];
    logic [31:0] expBranches;
    logic [31:0] expMis;
    vec_t        vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    // Reference branch semantics: returns 1 when the code is recognised.
    function automatic bit refResolve(input logic [5:0] code, input logic [31:0] a,
                                      input logic [31:0] b, output bit dir);
        int sa;
        sa  = int'(a);
        dir = 1'b0;
        case (code)
            6'h03:   dir = (a == b);
            6'h04:   dir = (a != b);
            6'h07:   dir = (sa <= 0);
            6'h0F:   dir = (sa > 0);
            6'h11:   dir = (sa >= 0);
            6'h13:   dir = (sa < 0);
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) bht[i] = 1;
        expBranches = 32'd0;
        expMis      = 32'd0;
    endtask

    task automatic checkStats(input string tag);
`ifdef BRU_STATS_EN
        checkOutput({tag, " stat_branches"}, stat_branches, expBranches);
        checkOutput({tag, " stat_mispredicts"}, stat_mispredicts, expMis);
`else
        checkOutput({tag, " stat_branches"}, stat_branches, 32'd0);
        checkOutput({tag, " stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
    endtask

    task automatic applyStimulus(input bit v, input logic [5:0] code, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b, input bit pred,
                                 input logic [31:0] lpc, input string tag,
                                 output bit oTaken, output bit oMis);
        bit dir;
        bit known;
        @(negedge clk);
        res_valid = v;
        res_code  = code;
        res_pc    = pc;
        res_op0   = a;
        res_op1   = b;
        res_pred  = pred;
        lookup_pc = lpc;
        #1;
        checkOutput({tag, " predict"}, {31'd0, predict_taken}, {31'd0, bht[idxOf(lpc)] >= 2});
        @(posedge clk);
        #1;
        known  = refResolve(code, a, b, dir);
        oTaken = v && known && dir;
        oMis   = v && known && (dir != pred);
        if (v && known) begin
            if (dir) bht[idxOf(pc)] = (bht[idxOf(pc)] == 3) ? 3 : bht[idxOf(pc)] + 1;
            else     bht[idxOf(pc)] = (bht[idxOf(pc)] == 0) ? 0 : bht[idxOf(pc)] - 1;
            if (expBranches != 32'hFFFF_FFFF) expBranches = expBranches + 32'd1;
            if (oMis && expMis != 32'hFFFF_FFFF) expMis = expMis + 32'd1;
        end
        checkOutput({tag, " taken"}, {31'd0, taken}, {31'd0, oTaken});
        checkOutput({tag, " mispredict"}, {31'd0, mispredict}, {31'd0, oMis});
        res_valid = 1'b0;
    endtask

    task automatic checkPredict(input logic [31:0] lpc, input bit expected, input string tag);
        @(negedge clk);
        lookup_pc = lpc;
        #1;
        checkOutput({tag, " predict"}, {31'd0, predict_taken}, {31'd0, expected});
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        res_valid = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset taken", {31'd0, taken}, 32'd0);
        checkOutput("reset mispredict", {31'd0, mispredict}, 32'd0);
        @(posedge clk);
        #1;
        checkStats("reset");
        @(negedge clk);
        rst       = 1'b0;
        lookup_pc = 32'h40;
        #1;
        checkOutput("post-reset predict", {31'd0, predict_taken}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit t, m;
        logic [5:0] codes [7];
        rst       = 1'b1;
        res_valid = 1'b0;
        res_code  = 6'h00;
        res_pc    = 32'h0;
        res_op0   = 32'h0;
        res_op1   = 32'h0;
        res_pred  = 1'b0;
        lookup_pc = 32'h0;
        modelReset();

        vecs[0]  = '{1'b1, 6'h03, 32'h40, 32'd5,          32'd5,          1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 6'h04, 32'h44, 32'd5,          32'd6,          1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 6'h04, 32'h48, 32'd7,          32'd7,          1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 6'h13, 32'h4C, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 6'h0F, 32'h50, 32'd0,          32'd9,          1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 6'h07, 32'h54, 32'd0,          32'd0,          1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 6'h11, 32'h58, 32'd0,          32'd3,          1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 6'h11, 32'h5C, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 6'h0F, 32'h60, 32'h7FFF_FFFF,  32'd0,          1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 6'h07, 32'h64, 32'd1,          32'd0,          1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 6'h3F, 32'h68, 32'd1,          32'd1,          1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 6'h03, 32'h6C, 32'h8000_0001,  32'd1,          1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 6'h13, 32'h70, 32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 6'h03, 32'h74, 32'd5,          32'd5,          1'b0, 1'b0, 1'b0};

        doReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].code, vecs[i].pc, vecs[i].op0, vecs[i].op1,
                          vecs[i].pred, vecs[i].pc, $sformatf("vec%0d", i), t, m);
            checkOutput($sformatf("vec%0d table taken", i), {31'd0, taken}, {31'd0, vecs[i].expTaken});
            checkOutput($sformatf("vec%0d table mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].expMis});
        end
        checkPredict(32'h40, 1'b1, "beq trained");
        checkPredict(32'h68, 1'b0, "bad code untouched");
        checkStats("table");

        // Counter walk at 0x80: 01 -> 10 -> 11 -> 11, then down to 10 and 01.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'h04, 32'h80, 32'd1, 32'd2, 1'b1, 32'h80, $sformatf("walk%0d", i), t, m);
            checkPredict(32'h80, 1'b1, $sformatf("walk%0d after", i));
        end
        applyStimulus(1'b1, 6'h04, 32'h80, 32'd3, 32'd3, 1'b1, 32'h80, "walk nt1", t, m);
        checkPredict(32'h80, 1'b1, "walk nt1 after");
        applyStimulus(1'b1, 6'h04, 32'h80, 32'd3, 32'd3, 1'b1, 32'h80, "walk nt2", t, m);
        checkPredict(32'h80, 1'b0, "walk nt2 after");

        // Same-cycle lookup of index 3 sees the pre-update counter.
        doReset();
        applyStimulus(1'b1, 6'h03, 32'h0C, 32'd1, 32'd1, 1'b0, 32'h0C, "bypass", t, m);
        checkPredict(32'h0C, 1'b1, "bypass next");

        // Reset wins over a simultaneous mispredicting resolve.
        applyStimulus(1'b1, 6'h03, 32'h40, 32'd2, 32'd2, 1'b1, 32'h40, "pretrain", t, m);
        @(negedge clk);
        rst       = 1'b1;
        res_valid = 1'b1;
        res_code  = 6'h03;
        res_pc    = 32'h40;
        res_op0   = 32'd5;
        res_op1   = 32'd6;
        res_pred  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst+resolve mispredict", {31'd0, mispredict}, 32'd0);
        checkOutput("rst+resolve taken", {31'd0, taken}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        res_valid = 1'b0;
        modelReset();
        #1;
        checkOutput("rst+resolve next mispredict", {31'd0, mispredict}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            checkPredict(32'(i * 4), 1'b0, $sformatf("rst idx%0d", i));
        end

        // Ten resolves with three mispredicts plus one unrecognised code.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 6'h03, 32'(32'h100 + i * 4), 32'd9, 32'd9, (i >= 3),
                          32'h0, $sformatf("stat%0d", i), t, m);
        end
        applyStimulus(1'b1, 6'h3F, 32'h200, 32'd9, 32'd9, 1'b0, 32'h0, "stat bad", t, m);
`ifdef BRU_STATS_EN
        checkOutput("stat10 branches", stat_branches, 32'd10);
        checkOutput("stat10 mispredicts", stat_mispredicts, 32'd3);
`else
        checkOutput("stat10 branches", stat_branches, 32'd0);
        checkOutput("stat10 mispredicts", stat_mispredicts, 32'd0);
`endif

        // Randomized traffic over a few indices so resolves collide often.
        codes[0] = 6'h03; codes[1] = 6'h04; codes[2] = 6'h07; codes[3] = 6'h0F;
        codes[4] = 6'h11; codes[5] = 6'h13; codes[6] = 6'h00;
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  code;
            logic [31:0] a, b, pc, lpc;
            int          sel;
            code = codes[$urandom_range(0, 6)];
            if (code == 6'h00) code = 6'($urandom);
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = 32'd0;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                3:       a = 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            b   = ($urandom_range(0, 1) == 1) ? a : (($urandom_range(0, 1) == 1) ? (a ^ 32'h8000_0000) : $urandom);
            pc  = ($urandom & ~32'h0000_00FC) | 32'($urandom_range(0, 7) << 2);
            lpc = ($urandom & ~32'h0000_00FC) | 32'($urandom_range(0, 7) << 2);
            applyStimulus(($urandom_range(0, 4) != 0), code, pc, a, b, 1'($urandom),
                          lpc, $sformatf("rnd%0d", i), t, m);
        end
        checkStats("random");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
